// File: rtl/req_encoder_arb_pkg.sv
// Shared widths and FSM state type for the request encoder/arbiter.
package req_encoder_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned CODE_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/req_encoder_arb_rr_pick8.sv
// Combinational 8-way picker: rotate by ptr, lowest-set-bit encode, rotate back.
module rr_pick8
  import req_encoder_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [CODE_W-1:0]  ptr,
  input  logic               rr_en,
  output logic [CODE_W-1:0]  winner,
  output logic               any
);

  logic [CODE_W-1:0]    sh;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [CODE_W-1:0]    idx;
  logic                 found;

  always_comb begin
    sh    = rr_en ? ptr : '0;
    dbl   = {req, req} >> sh;
    rot   = dbl[NUM_REQ-1:0];
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rot[i] && !found) begin
        idx   = CODE_W'(i);
        found = 1'b1;
      end
    end
    // Modulo-8 add undoes the rotation.
    winner = idx + sh;
    any    = |req;
  end

endmodule

// File: rtl/req_encoder_arb.sv
// Request encoder/arbiter: registered 3-bit grant index with hold timeout.
module req_encoder_arb
  import req_encoder_arb_pkg::*;
#(
  parameter int unsigned RR_EN    = 1,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  output logic               timeout
);

  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic             RR_ON     = (RR_EN != 0);

  state_t            state, state_d;
  logic [CODE_W-1:0] ptr, ptr_d, code_d, winner;
  logic [CNT_W-1:0]  hold_cnt, cnt_d;
  logic              valid_d, timeout_d, any;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .rr_en  (RR_ON),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d   = state;
    code_d    = code;
    valid_d   = valid;
    timeout_d = 1'b0;
    ptr_d     = ptr;
    cnt_d     = hold_cnt;
    case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (any) begin
          code_d  = winner;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[code]) begin
          valid_d = 1'b0;
          ptr_d   = code + 1'b1;
          state_d = IDLE;
        end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = code + 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      code     <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      code     <= code_d;
      valid    <= valid_d;
      timeout  <= timeout_d;
      ptr      <= ptr_d;
      hold_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_req_encoder_arb.sv
// Directed bench: round-robin, fixed-priority and short-timeout instances on one clock.
module tb_req_encoder_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b, req_c;
  logic [2:0] code_a, code_b, code_c;
  logic       valid_a, valid_b, valid_c;
  logic       to_a, to_b, to_c;
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  req_encoder_arb #(.RR_EN(1), .MAX_HOLD(16), .CNT_W(5)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req_a), .code(code_a), .valid(valid_a), .timeout(to_a));

  req_encoder_arb #(.RR_EN(0), .MAX_HOLD(16), .CNT_W(5)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req_b), .code(code_b), .valid(valid_b), .timeout(to_b));

  req_encoder_arb #(.RR_EN(1), .MAX_HOLD(4), .CNT_W(3)) dut_to (
    .clk(clk), .rst_n(rst_n), .req(req_c), .code(code_c), .valid(valid_c), .timeout(to_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = '0; req_b = '0; req_c = '0;
    tick(); tick();
    checks++; if (code_a !== 3'd0) begin fails++; $display("FAIL reset_code got %0d want 0", code_a); end
    checks++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_a); end
    checks++; if (to_a !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", to_a); end
    checks++; if (valid_c !== 1'b0) begin fails++; $display("FAIL reset_valid_to got %b want 0", valid_c); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_grant();
    req_a = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid_a !== 1'b1 || code_a !== 3'd2 || to_a !== 1'b0) begin
        fails++; $display("FAIL basic_grant[%0d] got v=%b c=%0d t=%b want v=1 c=2 t=0", i, valid_a, code_a, to_a);
      end
    end
    req_a = '0;
    tick();
    checks++; if (valid_a !== 1'b0) begin fails++; $display("FAIL basic_release got v=%b want 0", valid_a); end
    checks++; if (dut_rr.ptr !== 3'd3) begin fails++; $display("FAIL basic_ptr got %0d want 3", dut_rr.ptr); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'd7; exp_seq[1] = 3'd0; exp_seq[2] = 3'd7; exp_seq[3] = 3'd0;
    req_a = 8'h81;
    tick();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (valid_a !== 1'b1 || code_a !== exp_seq[g]) begin
        fails++; $display("FAIL rr_grant[%0d] got v=%b c=%0d want v=1 c=%0d", g, valid_a, code_a, exp_seq[g]);
      end
      req_a = 8'h81 & ~(8'h01 << exp_seq[g]);
      tick();
      checks++;
      if (valid_a !== 1'b0) begin fails++; $display("FAIL rr_gap[%0d] got v=%b want 0", g, valid_a); end
      req_a = (g == 3) ? 8'h00 : 8'h81;
      tick();
    end
    checks++; if (dut_rr.ptr !== 3'd1) begin fails++; $display("FAIL rr_ptr got %0d want 1", dut_rr.ptr); end
  endtask

  task automatic test_fixed_priority();
    req_b = 8'hF0;
    tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (valid_b !== 1'b1 || code_b !== 3'd4) begin
        fails++; $display("FAIL fp_grant[%0d] got v=%b c=%0d want v=1 c=4", g, valid_b, code_b);
      end
      req_b = 8'hE0;
      tick();
      checks++; if (valid_b !== 1'b0) begin fails++; $display("FAIL fp_gap[%0d] got v=%b want 0", g, valid_b); end
      req_b = 8'hF0;
      tick();
    end
    // a lower-index request arriving mid-grant must not preempt
    req_b = 8'hF1;
    tick();
    checks++; if (valid_b !== 1'b1 || code_b !== 3'd4) begin fails++; $display("FAIL fp_no_preempt got v=%b c=%0d want v=1 c=4", valid_b, code_b); end
    req_b = 8'h01;
    tick();
    checks++; if (valid_b !== 1'b0) begin fails++; $display("FAIL fp_release got v=%b want 0", valid_b); end
    tick();
    checks++; if (valid_b !== 1'b1 || code_b !== 3'd0) begin fails++; $display("FAIL fp_next got v=%b c=%0d want v=1 c=0", valid_b, code_b); end
    req_b = '0;
  endtask

  task automatic test_timeout();
    req_c = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (valid_c !== 1'b1 || code_c !== 3'd5 || to_c !== 1'b0) begin
        fails++; $display("FAIL to_hold[%0d] got v=%b c=%0d t=%b want v=1 c=5 t=0", i, valid_c, code_c, to_c);
      end
    end
    tick();
    checks++; if (valid_c !== 1'b0 || to_c !== 1'b1) begin fails++; $display("FAIL to_fire got v=%b t=%b want v=0 t=1", valid_c, to_c); end
    checks++; if (dut_to.ptr !== 3'd6) begin fails++; $display("FAIL to_ptr got %0d want 6", dut_to.ptr); end
    tick();
    checks++; if (valid_c !== 1'b1 || code_c !== 3'd5 || to_c !== 1'b0) begin fails++; $display("FAIL to_regrant got v=%b c=%0d t=%b want v=1 c=5 t=0", valid_c, code_c, to_c); end
    req_c = '0;
  endtask

  task automatic test_reset_mid_grant();
    req_a = 8'h40;
    tick();
    checks++; if (valid_a !== 1'b1 || code_a !== 3'd6) begin fails++; $display("FAIL mid_pre got v=%b c=%0d want v=1 c=6", valid_a, code_a); end
    rst_n = 1'b0;
    tick();
    checks++; if (valid_a !== 1'b0 || code_a !== 3'd0 || to_a !== 1'b0) begin fails++; $display("FAIL mid_reset got v=%b c=%0d t=%b want v=0 c=0 t=0", valid_a, code_a, to_a); end
    rst_n = 1'b1;
    tick();
    checks++; if (valid_a !== 1'b1 || code_a !== 3'd6) begin fails++; $display("FAIL mid_regrant got v=%b c=%0d want v=1 c=6", valid_a, code_a); end
  endtask

  task automatic test_wrap_and_idle();
    req_a = '0;
    tick();
    checks++; if (dut_rr.ptr !== 3'd7) begin fails++; $display("FAIL wrap_ptr got %0d want 7", dut_rr.ptr); end
    req_a = 8'h01;
    tick();
    checks++; if (valid_a !== 1'b1 || code_a !== 3'd0) begin fails++; $display("FAIL wrap_grant got v=%b c=%0d want v=1 c=0", valid_a, code_a); end
    req_a = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (valid_a !== 1'b0 || code_a !== 3'd0 || to_a !== 1'b0) begin
        fails++; $display("FAIL idle[%0d] got v=%b c=%0d t=%b want v=0 c=0 t=0", i, valid_a, code_a, to_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_reset_mid_grant();
    test_wrap_and_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
